lap_stopwatch: RTL and testbench

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

---
 rtl/sw_pkg.sv | 27 ++
 rtl/sw_time_counter.sv | 96 +++++++++
 rtl/lap_stopwatch.sv | 127 ++++++++++++
 tb/tb_lap_stopwatch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared widths, limits and the packed time record used by the stopwatch.
package sw_pkg;

  localparam int SEC_W  = 7;
  localparam int MIN_W  = 7;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 7'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 7'd59;

  // One stored time value; hour in the top bits so records compare naturally.
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_rec_t;

  // All-zero record, used for cleared slots and out-of-range reads.
  function automatic time_rec_t time_rec_zero();
    time_rec_t r;
    r.hour = {HOUR_W{1'b0}};
    r.min  = {MIN_W{1'b0}};
    r.sec  = {SEC_W{1'b0}};
    return r;
  endfunction

endpackage

// File: rtl/sw_time_counter.sv
// Prescaler plus sec/min/hour cascade. The prescaler is held, not
// cleared, while stop is high so a paused second resumes where it left off.
// ring is registered so it rises in the same cycle the hour update appears.
module sw_time_counter
  import sw_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int HOUR_MAX      = 24
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clear_i,
  input  logic      stop_i,
  output time_rec_t time_o,
  output logic      ring_o
);

  localparam int PS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX - 1);

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic              ring_q, ring_d;
  logic              tick_s;

  // Next-state for prescaler and the carry chain; clear overrides everything.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    ring_d  = 1'b0;
    tick_s  = 1'b0;
    if (clear_i) begin
      presc_d = {PS_W{1'b0}};
      sec_d   = {SEC_W{1'b0}};
      min_d   = {MIN_W{1'b0}};
      hour_d  = {HOUR_W{1'b0}};
    end else if (!stop_i) begin
      if (presc_q == PS_LAST) begin
        presc_d = {PS_W{1'b0}};
        tick_s  = 1'b1;
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
      if (tick_s) begin
        if (sec_q == SEC_MAX) begin
          sec_d = {SEC_W{1'b0}};
          if (min_q == MIN_MAX) begin
            min_d  = {MIN_W{1'b0}};
            ring_d = 1'b1;
            if (hour_q == HOUR_LAST) begin
              hour_d = {HOUR_W{1'b0}};
            end else begin
              hour_d = hour_q + HOUR_W'(1);
            end
          end else begin
            min_d = min_q + MIN_W'(1);
          end
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end else begin
        sec_d = sec_q;
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Time and ring registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= {PS_W{1'b0}};
      sec_q   <= {SEC_W{1'b0}};
      min_q   <= {MIN_W{1'b0}};
      hour_q  <= {HOUR_W{1'b0}};
      ring_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      ring_q  <= ring_d;
    end
  end

  assign time_o.hour = hour_q;
  assign time_o.min  = min_q;
  assign time_o.sec  = sec_q;
  assign ring_o      = ring_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch with a lap ring buffer. Captures store the registered time
// (the pre-increment value when a tick coincides). Reads are combinational,
// indexed back from the newest record.
module lap_stopwatch
  import sw_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int LAP_DEPTH     = 4,
  parameter int HOUR_MAX      = 24,
  parameter int OVERWRITE     = 1,
  localparam int PTR_W = $clog2(LAP_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop,
  input  logic              record,
  input  logic              clear,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic              ring,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [SEC_W-1:0]  rec_sec,
  output logic [MIN_W-1:0]  rec_min,
  output logic [HOUR_W-1:0] rec_hour,
  output logic [CNT_W-1:0]  lap_count,
  output logic              lap_full
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

  time_rec_t            time_s;
  time_rec_t            lap_mem_q [LAP_DEPTH];
  time_rec_t            rd_rec_s;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     lap_count_q, lap_count_d;
  logic                 lap_full_q, lap_full_d;
  logic                 rec_prev_q, rec_prev_d;
  logic                 cap_edge_s;
  logic                 cap_en_s;
  logic [PTR_W-1:0]     rd_slot_s;
  logic                 rd_valid_s;

  sw_time_counter #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .HOUR_MAX      (HOUR_MAX)
  ) u_time (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (clear),
    .stop_i  (stop),
    .time_o  (time_s),
    .ring_o  (ring)
  );

  // Edge detect on record and pointer/count bookkeeping for a capture.
  always_comb begin
    cap_edge_s  = record & ~rec_prev_q;
    rec_prev_d  = record;
    wr_ptr_d    = wr_ptr_q;
    lap_count_d = lap_count_q;
    cap_en_s    = 1'b0;
    if (clear) begin
      rec_prev_d  = 1'b0;
      wr_ptr_d    = {PTR_W{1'b0}};
      lap_count_d = {CNT_W{1'b0}};
    end else if (cap_edge_s && (!lap_full_q || (OVERWRITE != 0))) begin
      cap_en_s = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (lap_full_q) begin
        lap_count_d = lap_count_q;
      end else begin
        lap_count_d = lap_count_q + CNT_W'(1);
      end
    end else begin
      cap_en_s = 1'b0;
    end
    lap_full_d = (lap_count_d == CNT_FULL);
  end

  // Lap control registers and buffer storage; clear wipes every slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      lap_count_q <= {CNT_W{1'b0}};
      lap_full_q  <= 1'b0;
      rec_prev_q  <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lap_mem_q[i] <= time_rec_zero();
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      lap_count_q <= lap_count_d;
      lap_full_q  <= lap_full_d;
      rec_prev_q  <= rec_prev_d;
      if (clear) begin
        for (int i = 0; i < LAP_DEPTH; i++) begin
          lap_mem_q[i] <= time_rec_zero();
        end
      end else if (cap_en_s) begin
        lap_mem_q[wr_ptr_q] <= time_s;
      end
    end
  end

  // Newest-first read; slots beyond the stored count read as zero.
  always_comb begin
    rd_slot_s  = wr_ptr_q - PTR_W'(1) - rd_idx;
    rd_valid_s = ({1'b0, rd_idx} < lap_count_q);
    if (rd_valid_s) begin
      rd_rec_s = lap_mem_q[rd_slot_s];
    end else begin
      rd_rec_s = time_rec_zero();
    end
  end

  assign sec       = time_s.sec;
  assign min       = time_s.min;
  assign hour      = time_s.hour;
  assign rec_sec   = rd_rec_s.sec;
  assign rec_min   = rd_rec_s.min;
  assign rec_hour  = rd_rec_s.hour;
  assign lap_count = lap_count_q;
  assign lap_full  = lap_full_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch. Four instances share inputs:
// a = defaults, b = HOUR_MAX 2, c = OVERWRITE 0, d = TICKS_PER_SEC 4.
module tb_lap_stopwatch;

  logic       clk = 1'b0;
  logic       reset, stop, record, clear;
  logic [1:0] rd_idx;

  logic a_ring, b_ring, c_ring, d_ring;
  logic [6:0] a_sec, b_sec, c_sec, d_sec, a_min, b_min, c_min, d_min;
  logic [4:0] a_hour, b_hour, c_hour, d_hour;
  logic [6:0] a_rsec, b_rsec, c_rsec, d_rsec, a_rmin, b_rmin, c_rmin, d_rmin;
  logic [4:0] a_rhour, b_rhour, c_rhour, d_rhour;
  logic [2:0] a_cnt, b_cnt, c_cnt, d_cnt;
  logic a_full, b_full, c_full, d_full;

  int n_total = 0;
  int n_bad   = 0;
  int a_rings, b_rings;
  int exp_ow1 [4] = '{5, 4, 3, 2};
  int exp_ow0 [4] = '{4, 3, 2, 1};

  always #5 clk = ~clk;

  lap_stopwatch #(.TICKS_PER_SEC(1), .LAP_DEPTH(4), .HOUR_MAX(24), .OVERWRITE(1)) dut_a (
    .clk(clk), .reset(reset), .stop(stop), .record(record), .clear(clear), .rd_idx(rd_idx),
    .ring(a_ring), .sec(a_sec), .min(a_min), .hour(a_hour), .rec_sec(a_rsec),
    .rec_min(a_rmin), .rec_hour(a_rhour), .lap_count(a_cnt), .lap_full(a_full));

  lap_stopwatch #(.TICKS_PER_SEC(1), .LAP_DEPTH(4), .HOUR_MAX(2), .OVERWRITE(1)) dut_b (
    .clk(clk), .reset(reset), .stop(stop), .record(record), .clear(clear), .rd_idx(rd_idx),
    .ring(b_ring), .sec(b_sec), .min(b_min), .hour(b_hour), .rec_sec(b_rsec),
    .rec_min(b_rmin), .rec_hour(b_rhour), .lap_count(b_cnt), .lap_full(b_full));

  lap_stopwatch #(.TICKS_PER_SEC(1), .LAP_DEPTH(4), .HOUR_MAX(24), .OVERWRITE(0)) dut_c (
    .clk(clk), .reset(reset), .stop(stop), .record(record), .clear(clear), .rd_idx(rd_idx),
    .ring(c_ring), .sec(c_sec), .min(c_min), .hour(c_hour), .rec_sec(c_rsec),
    .rec_min(c_rmin), .rec_hour(c_rhour), .lap_count(c_cnt), .lap_full(c_full));

  lap_stopwatch #(.TICKS_PER_SEC(4), .LAP_DEPTH(4), .HOUR_MAX(24), .OVERWRITE(1)) dut_d (
    .clk(clk), .reset(reset), .stop(stop), .record(record), .clear(clear), .rd_idx(rd_idx),
    .ring(d_ring), .sec(d_sec), .min(d_min), .hour(d_hour), .rec_sec(d_rsec),
    .rec_min(d_rmin), .rec_hour(d_rhour), .lap_count(d_cnt), .lap_full(d_full));

  // Count ring pulses of the two long-running instances.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rings <= 0;
      b_rings <= 0;
    end else begin
      if (a_ring) a_rings <= a_rings + 1;
      if (b_ring) b_rings <= b_rings + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    stop   = 1'b0;
    record = 1'b0;
    clear  = 1'b0;
    rd_idx = 2'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle record pulse; time advances by one second meanwhile.
  task automatic pulse_rec();
    record = 1'b1;
    @(negedge clk);
    record = 1'b0;
  endtask

  // Capture the current second, then pause one cycle with record low.
  task automatic cap_step();
    record = 1'b1;
    stop   = 1'b0;
    @(negedge clk);
    record = 1'b0;
    stop   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got=0 expected=1");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; stop = 1'b0; record = 1'b0; clear = 1'b0; rd_idx = 2'd0;
    #1;
    check_val("rst_sec", a_sec, 0);
    check_val("rst_cnt", a_cnt, 0);
    check_val("rst_ring", a_ring, 0);
    check_val("rst_rsec", a_rsec, 0);
    @(negedge clk);
    reset = 1'b0;

    // Free-running counting and hour rollover.
    run(125);
    check_val("t125_min", a_min, 2);
    check_val("t125_sec", a_sec, 5);
    check_val("t125_hour", a_hour, 0);
    check_val("t125_rings", a_rings, 0);
    run(3475);
    check_val("t3600_hour", a_hour, 1);
    check_val("t3600_min", a_min, 0);
    check_val("t3600_sec", a_sec, 0);
    check_val("t3600_ring", a_ring, 1);
    run(1);
    check_val("t3601_rings", a_rings, 1);
    check_val("t3601_ring_low", a_ring, 0);
    run(3599);
    check_val("h2_hour_wrap", b_hour, 0);
    check_val("h2_min", b_min, 0);
    check_val("h2_sec", b_sec, 0);
    check_val("t7200_hour", a_hour, 2);
    run(1);
    check_val("h2_rings", b_rings, 2);
    check_val("t7201_rings", a_rings, 2);

    // Two laps at 10 s and 20 s.
    do_reset();
    run(10);
    pulse_rec();
    run(9);
    pulse_rec();
    stop = 1'b1;
    run(2);
    check_val("lap2_cnt", a_cnt, 2);
    check_val("lap2_full", a_full, 0);
    rd_idx = 2'd0; #1;
    check_val("lap2_rd0", a_rsec, 20);
    rd_idx = 2'd1; #1;
    check_val("lap2_rd1", a_rsec, 10);
    rd_idx = 2'd2; #1;
    check_val("lap2_rd2", a_rsec, 0);

    // Five captures at 1..5 s into a four-deep buffer.
    do_reset();
    run(1);
    repeat (5) cap_step();
    check_val("ow1_cnt", a_cnt, 4);
    check_val("ow1_full", a_full, 1);
    check_val("ow0_cnt", c_cnt, 4);
    check_val("ow0_full", c_full, 1);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check_val($sformatf("ow1_rd%0d", i), a_rsec, exp_ow1[i]);
      check_val($sformatf("ow0_rd%0d", i), c_rsec, exp_ow0[i]);
    end

    // Stop freezes time; held record captures once.
    do_reset();
    run(7);
    stop = 1'b1;
    run(3);
    record = 1'b1;
    run(5);
    record = 1'b0;
    run(12);
    check_val("stop_sec", a_sec, 7);
    check_val("stop_cnt", a_cnt, 1);
    check_val("stop_rd0", a_rsec, 7);

    // Prescaler of four, held across a pause.
    do_reset();
    run(3);
    check_val("t4_sec_3cyc", d_sec, 0);
    run(1);
    check_val("t4_sec_4cyc", d_sec, 1);
    run(2);
    stop = 1'b1;
    run(5);
    stop = 1'b0;
    run(1);
    check_val("t4_hold_a", d_sec, 1);
    run(1);
    check_val("t4_hold_b", d_sec, 2);

    // Clear with a coinciding record edge and tick.
    do_reset();
    run(3);
    pulse_rec();
    run(2);
    check_val("pre_clr_cnt", a_cnt, 1);
    clear = 1'b1;
    record = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    record = 1'b0;
    check_val("clr_sec", a_sec, 0);
    check_val("clr_cnt", a_cnt, 0);
    check_val("clr_full", a_full, 0);
    check_val("clr_rd0", a_rsec, 0);
    check_val("clr_ring", a_ring, 0);
    run(3);
    check_val("clr_t4_presc", d_sec, 0);
    run(1);
    check_val("clr_t4_sec", d_sec, 1);
    check_val("clr_run_sec", a_sec, 4);

    // Asynchronous reset in the middle of a cycle.
    pulse_rec();
    run(2);
    check_val("pre_rst_cnt", a_cnt, 1);
    check_val("pre_rst_sec", a_sec, 7);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_sec", a_sec, 0);
    check_val("async_cnt", a_cnt, 0);
    check_val("async_rd0", a_rsec, 0);
    @(negedge clk);
    reset = 1'b0;
    run(1);
    check_val("resume_sec", a_sec, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
